vga_fb_scanout: RTL

Downstream stage of the 640x480 VGA timing core. It consumes the pixel strobe, syncs, active flag, screen-end pulse and x/y position from that core. It reads Mandelbrot iteration counts from a double-buffered, downscaled frame buffer, maps each count to 12-bit RGB, and drives the VGA pins with syncs delay-matched to the pixel data. It also performs the front/back buffer swap handshake with the renderer, aligned to the end of the screen.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/mandel_palette.sv | 59 +++++
 rtl/vga_fb_scanout.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame-buffer scanout path.
package vga_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;

  // Strobes from timing-core input to the VGA pins.
  localparam int PIPE_DEPTH = 3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    WAIT_LOW = 2'd2
  } swap_state_t;

endpackage

// File: rtl/mandel_palette.sv
// Registered iteration-count to RGB444 mapping (pipeline stage S2).
// Optional macro PALETTE_LUT_EN selects a 256x12 lookup table.
module mandel_palette
  import vga_pkg::*;
#(
  parameter int ITER_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_active,
  input  logic [ITER_W-1:0] i_iter,
  output rgb12_t            o_rgb
);

  logic [7:0] idx;
  logic       in_set;
  rgb12_t     rgb_d;
  rgb12_t     rgb_q;

  assign idx    = i_iter[ITER_W-1 -: 8];
  assign in_set = &i_iter;

`ifdef PALETTE_LUT_EN
  function automatic logic [11:0] lut_entry(input int n);
    logic [7:0] v;
    v = 8'(n);
    return {v[3:0], v[5:2], v[7:4]};
  endfunction

  logic [11:0] lut [256];

  for (genvar k = 0; k < 256; k++) begin : g_lut
    assign lut[k] = lut_entry(k);
  end

  always_comb begin
    rgb_d = lut[idx];
  end
`else
  always_comb begin
    rgb_d.r = idx[3:0];
    rgb_d.g = idx[5:2];
    rgb_d.b = idx[7:4];
  end
`endif

  // In-set points are black whatever the mapping says.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_q <= '0;
    end else if (i_en) begin
      rgb_q <= (!i_active || in_set) ? '0 : rgb_d;
    end
  end

  assign o_rgb = rgb_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// Frame-buffer scanout: address gen, data capture, palette, delay-matched syncs
// and screen-end aligned bank swap. See mandel_palette for PALETTE_LUT_EN.
module vga_fb_scanout #(
  parameter int H_RES       = vga_pkg::H_RES,
  parameter int V_RES       = vga_pkg::V_RES,
  parameter int SCALE_SHIFT = 1,
  parameter int ITER_W      = 8,
  parameter int ADDR_W      = 17
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pix_stb,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_active,
  input  logic              i_screenend,
  input  logic [9:0]        i_x,
  input  logic [8:0]        i_y,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_bank,
  input  logic [ITER_W-1:0] i_rd_data,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic              o_vga_hs,
  output logic              o_vga_vs,
  output logic [3:0]        o_vga_r,
  output logic [3:0]        o_vga_g,
  output logic [3:0]        o_vga_b
);

  localparam int DEPTH = vga_pkg::PIPE_DEPTH;
  localparam int FB_W  = H_RES >> SCALE_SHIFT;
  localparam int FB_H  = V_RES >> SCALE_SHIFT;

  if (FB_W * FB_H - 1 >= (1 << ADDR_W)) begin : g_addr_chk
    $error("ADDR_W too narrow for the downscaled frame buffer");
  end

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              rd_en_q;
  logic [DEPTH-1:0]  hs_q, vs_q;
  logic [DEPTH-2:0]  act_q;
  logic [ITER_W-1:0] data_q;
  vga_pkg::rgb12_t   rgb;

  assign addr_d = ADDR_W'(ADDR_W'(i_y >> SCALE_SHIFT) * ADDR_W'(FB_W))
                + ADDR_W'(i_x >> SCALE_SHIFT);

  // S0 address/read, S1 data capture; syncs ride a matching shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      hs_q    <= '1;
      vs_q    <= '1;
      act_q   <= '0;
      data_q  <= '0;
    end else begin
      rd_en_q <= i_pix_stb & i_active;
      if (i_pix_stb) begin
        addr_q <= addr_d;
        hs_q   <= {hs_q[DEPTH-2:0], i_hs};
        vs_q   <= {vs_q[DEPTH-2:0], i_vs};
        act_q  <= {act_q[DEPTH-3:0], i_active};
        data_q <= i_rd_data;
      end
    end
  end

  mandel_palette #(.ITER_W(ITER_W)) u_palette (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (i_pix_stb),
    .i_active (act_q[DEPTH-2]),
    .i_iter   (data_q),
    .o_rgb    (rgb)
  );

  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = addr_q;
  assign o_vga_hs  = hs_q[DEPTH-1];
  assign o_vga_vs  = vs_q[DEPTH-1];
  assign o_vga_r   = rgb.r;
  assign o_vga_g   = rgb.g;
  assign o_vga_b   = rgb.b;

  vga_pkg::swap_state_t state_q, state_d;
  logic                 swap_fire;
  logic                 bank_q;
  logic                 ack_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= vga_pkg::IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      vga_pkg::IDLE:     if (i_swap_req) state_d = vga_pkg::PENDING;
      vga_pkg::PENDING:  if (i_screenend && i_pix_stb) state_d = vga_pkg::WAIT_LOW;
      vga_pkg::WAIT_LOW: if (!i_swap_req) state_d = vga_pkg::IDLE;
      default:           state_d = vga_pkg::IDLE;
    endcase
  end

  always_comb begin
    swap_fire = (state_q == vga_pkg::PENDING) && i_screenend && i_pix_stb;
  end

  // Bank flips only on the screen-end strobe, so a frame never mixes banks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= swap_fire;
      if (swap_fire) bank_q <= ~bank_q;
    end
  end

  assign o_rd_bank  = bank_q;
  assign o_swap_ack = ack_q;

endmodule
